ddfs_mc: RTL

- Time-multiplexed, parametrised multi-channel direct digital frequency synthesiser.
- Successor to the single-channel DDFS core. Adds the following over it:
  - NCH channels sharing one sine ROM and one multiplier.
  - Per-channel waveform select: sine, square, sawtooth, triangle.
  - Per-channel register file written over a simple write port.
  - Saturating mixer producing one 16-bit PCM sample per frame.
- Sits between the CPU-side register bridge and the audio PWM/DAC stage.
- `tick` comes from the sample-rate divider.

---
 rtl/ddfs_mc.sv | 389 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ddfs_mc.sv
`timescale 1ns / 1ps
// ============================================================================
// ddfs_mc -- time-multiplexed multi-channel direct digital frequency synthesiser
//
// NCH channels share one sine ROM and one 16x16 multiplier. A tick starts a
// frame. The sequencer then visits one channel per clock (RUN) and flushes
// the three-stage datapath (DRAIN). The per-channel terms are summed with
// saturation into one 16-bit PCM sample per frame.
//
// Datapath stages for the channel in slot ch:
//   stage 0 : address phase = phase[ch] + pha[ch]; ROM read issued;
//             phase[ch] advances by fccw + focw
//   stage 1 : waveform select (ROM data arrives here), env * wave
//   stage 2 : accumulate term = product[29:14] into the mixer
// tick in cycle 0 -> pcm_valid_o in cycle NCH+4.
//
// Parameters:
//   NCH : number of channels (2..16)
//   PW  : phase accumulator width (>= 16)
//   OW  : PCM width, must stay 16
//
// Ports:
//   clk_i       system clock
//   rst_n_i     asynchronous active-low reset
//   tick_i      one-cycle sample strobe, starts a frame
//   wr_en_i     register write strobe
//   wr_ch_i     target channel of the write
//   wr_sel_i    0=fccw 1=focw 2=pha 3=env 4=wave 5=phase clear 7=ovr clear
//   wr_data_i   write data (env uses [15:0], wave uses [2:0])
//   pcm_out_o   mixed signed sample
//   pcm_valid_o one-cycle pulse when pcm_out_o updates
//   pulse_out_o per-channel phase MSB (square sync)
//   busy_o      frame in progress
//   ovr_o       sticky: tick arrived while busy
//
// Optional feature (macro DDFS_MC_NOISE_EN): wave code 4 selects a
// per-channel 16-bit LFSR noise source. Without the macro, code 4 gives 0
// and no LFSR is built.
// ============================================================================
module ddfs_mc #(
    parameter int NCH = 4,
    parameter int PW  = 30,
    parameter int OW  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   tick_i,
    input  logic                   wr_en_i,
    input  logic [$clog2(NCH)-1:0] wr_ch_i,
    input  logic [2:0]             wr_sel_i,
    input  logic [PW-1:0]          wr_data_i,
    output logic [OW-1:0]          pcm_out_o,
    output logic                   pcm_valid_o,
    output logic [NCH-1:0]         pulse_out_o,
    output logic                   busy_o,
    output logic                   ovr_o
);

    localparam int CW = $clog2(NCH);
    // Mixer width: NCH full-scale 16-bit terms cannot overflow this.
    localparam int AW = OW + CW;

    // ------------------------------------------------------------------
    // Sine ROM contents. A quarter wave is evaluated at elaboration with a
    // 64-bit fixed-point Taylor series (Q30, pi*2^30 = 3373259426). The
    // table is then mirrored into 256 entries of round(32767*sin(2*pi*i/256)).
    // ------------------------------------------------------------------
    function automatic logic signed [15:0] quarter_sine(input int j);
        longint x;
        longint term;
        longint sum;
        longint r;
        x    = (longint'(j) * 64'sd3373259426) >>> 7;
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        r = (sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
        return 16'(r);
    endfunction

    function automatic logic signed [15:0] sine_entry(input int i);
        int j;
        int quad;
        logic signed [15:0] v;
        j    = i % 64;
        quad = i / 64;
        case (quad)
            0:       v = quarter_sine(j);
            1:       v = quarter_sine(64 - j);
            2:       v = -quarter_sine(j);
            default: v = -quarter_sine(64 - j);
        endcase
        return v;
    endfunction

    logic signed [15:0] sine_rom [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        assign sine_rom[gi] = sine_entry(gi);
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [1:0]    drain_q, drain_d;
    logic          frame_start;
    logic          slot_en;
    logic          frame_done;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        drain_d     = drain_q;
        frame_start = 1'b0;
        slot_en     = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick_i) begin
                    state_d     = S_RUN;
                    ch_d        = '0;
                    frame_start = 1'b1;
                end
            end
            S_RUN: begin
                slot_en = 1'b1;
                if (ch_q == CW'(NCH - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Third drain cycle: the last term has just been accumulated.
                if (drain_q == 2'd2) begin
                    state_d    = S_IDLE;
                    frame_done = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Per-channel register file and phase accumulators
    // ------------------------------------------------------------------
    logic [PW-1:0]      phase_q [NCH];
    logic [PW-1:0]      fccw_q  [NCH];
    logic [PW-1:0]      focw_q  [NCH];
    logic [PW-1:0]      pha_q   [NCH];
    logic signed [15:0] env_q   [NCH];
    logic [2:0]         wave_q  [NCH];
    logic               pulse_q [NCH];
`ifdef DDFS_MC_NOISE_EN
    logic [15:0]        lfsr_q  [NCH];
`endif

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic slot_hit;
        logic wr_hit;

        assign slot_hit = slot_en && (ch_q == CW'(gi));
        assign wr_hit   = wr_en_i && (wr_ch_i == CW'(gi));

        // The write decode comes after the slot update, so a phase clear in
        // the channel's own slot overrides the accumulate.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                phase_q[gi] <= '0;
                fccw_q[gi]  <= '0;
                focw_q[gi]  <= '0;
                pha_q[gi]   <= '0;
                env_q[gi]   <= '0;
                wave_q[gi]  <= '0;
                pulse_q[gi] <= 1'b0;
            end else begin
                if (slot_hit) begin
                    phase_q[gi] <= phase_q[gi] + fccw_q[gi] + focw_q[gi];
                    pulse_q[gi] <= phase_q[gi][PW-1];
                end
                if (wr_hit) begin
                    case (wr_sel_i)
                        3'd0:    fccw_q[gi]  <= wr_data_i;
                        3'd1:    focw_q[gi]  <= wr_data_i;
                        3'd2:    pha_q[gi]   <= wr_data_i;
                        3'd3:    env_q[gi]   <= wr_data_i[15:0];
                        3'd4:    wave_q[gi]  <= wr_data_i[2:0];
                        3'd5:    phase_q[gi] <= '0;
                        default: ;
                    endcase
                end
            end
        end

`ifdef DDFS_MC_NOISE_EN
        // Fibonacci LFSR, taps 16,14,13,11; one step per frame in this slot.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                lfsr_q[gi] <= 16'hACE1;
            end else if (wr_hit && (wr_sel_i == 3'd5)) begin
                lfsr_q[gi] <= 16'hACE1;
            end else if (slot_hit) begin
                lfsr_q[gi] <= {lfsr_q[gi][14:0],
                               lfsr_q[gi][15] ^ lfsr_q[gi][13] ^ lfsr_q[gi][12] ^ lfsr_q[gi][10]};
            end
        end
`endif

        assign pulse_out_o[gi] = pulse_q[gi];
    end

    // ------------------------------------------------------------------
    // Stage 0: addressing uses the pre-update phase
    // ------------------------------------------------------------------
    logic [PW-1:0] addr_phase;
    logic [15:0]   u_0;

    assign addr_phase = phase_q[ch_q] + pha_q[ch_q];
    assign u_0        = addr_phase[PW-1 -: 16];

    // ROM read register without reset so it maps onto block memory.
    logic signed [15:0] rom_q;

    always_ff @(posedge clk_i) begin
        rom_q <= sine_rom[u_0[15:8]];
    end

    // Non-ROM waveform inputs are registered alongside the ROM read.
    logic               s1_valid_q;
    logic [15:0]        s1_u_q;
    logic [2:0]         s1_wave_q;
    logic signed [15:0] s1_env_q;
`ifdef DDFS_MC_NOISE_EN
    logic [15:0]        s1_lfsr_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_u_q     <= '0;
            s1_wave_q  <= '0;
            s1_env_q   <= '0;
`ifdef DDFS_MC_NOISE_EN
            s1_lfsr_q  <= '0;
`endif
        end else begin
            s1_valid_q <= slot_en;
            s1_u_q     <= u_0;
            s1_wave_q  <= wave_q[ch_q];
            s1_env_q   <= env_q[ch_q];
`ifdef DDFS_MC_NOISE_EN
            s1_lfsr_q  <= lfsr_q[ch_q];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: waveform select and envelope multiply
    // ------------------------------------------------------------------
    logic [15:0]        tri_t;
    logic signed [15:0] wave_val;

    always_comb begin
        tri_t    = s1_u_q[15] ? ~{s1_u_q[14:0], 1'b0} : {s1_u_q[14:0], 1'b0};
        wave_val = '0;
        case (s1_wave_q)
            3'd0:    wave_val = rom_q;
            3'd1:    wave_val = s1_u_q[15] ? -16'sd32767 : 16'sd32767;
            3'd2:    wave_val = s1_u_q ^ 16'h8000;
            3'd3:    wave_val = tri_t ^ 16'h8000;
`ifdef DDFS_MC_NOISE_EN
            3'd4:    wave_val = s1_lfsr_q;
`endif
            default: wave_val = '0;
        endcase
    end

    logic               s2_valid_q;
    logic signed [31:0] prod_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            prod_q     <= s1_env_q * wave_val;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: mixer. env is Q2.14, so the term is product[29:14].
    // ------------------------------------------------------------------
    logic signed [15:0] term;
    logic               unused_prod_bits;
    logic signed [AW-1:0] acc_q;

    assign term             = prod_q[29:14];
    assign unused_prod_bits = ^{prod_q[31:30], prod_q[13:0]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else if (frame_start) begin
            acc_q <= '0;
        end else if (s2_valid_q) begin
            acc_q <= acc_q + {{(AW - 16){term[15]}}, term};
        end
    end

    // Saturate: in range only when all bits above the output sign agree.
    logic [AW-OW:0] acc_hi;
    logic [OW-1:0]  sat_val;

    assign acc_hi = acc_q[AW-1:OW-1];

    always_comb begin
        sat_val = acc_q[OW-1:0];
        if (!((acc_hi == '0) || (acc_hi == '1))) begin
            sat_val = acc_q[AW-1] ? {1'b1, {(OW - 1){1'b0}}} : {1'b0, {(OW - 1){1'b1}}};
        end
    end

    // ------------------------------------------------------------------
    // Output and overrun flag
    // ------------------------------------------------------------------
    logic [OW-1:0] pcm_q;
    logic          pcm_valid_q;
    logic          ovr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
        end else begin
            pcm_valid_q <= frame_done;
            if (frame_done) begin
                pcm_q <= sat_val;
            end
        end
    end

    // A tick during a frame is dropped but remembered; set beats clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovr_q <= 1'b0;
        end else begin
            if (wr_en_i && (wr_sel_i == 3'd7)) begin
                ovr_q <= 1'b0;
            end
            if (tick_i && (state_q != S_IDLE)) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign pcm_out_o   = pcm_q;
    assign pcm_valid_o = pcm_valid_q;
    assign ovr_o       = ovr_q;

endmodule
